truth_sweep: RTL and testbench

Sequential stimulus sequencer and response capturer for 3-input combinational logic blocks, such as the f5-style sum-of-products functions and their simplified forms. Its `stim` output drives a function's `{a,b,c}` inputs, stepping through every input combination on command. After a settle interval it samples the function's output for each combination. The result is a packed truth-table vector, plus an optional equivalence check against a second implementation. This replaces hand-written `#1` stimulus lists with a clocked, self-timed sweep.

---
 rtl/truth_sweep.sv | 97 +++++++++
 tb/tb_truth_sweep.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/truth_sweep.sv
// Clocked truth-table sweeper: steps stim over all 2^N input vectors and captures the responses.
// Define TRUTH_SWEEP_CMP_EN to capture resp_b and compare it against resp_a.
module truth_sweep #(
   parameter int unsigned N      = 3,
   parameter int unsigned SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N-1:0]      stim,
   input  logic              resp_a,
   input  logic              resp_b,
   output logic              busy,
   output logic              done,
   output logic [2**N-1:0]   table_a,
   output logic [2**N-1:0]   table_b,
   output logic              mismatch,
   output logic [N:0]        err_count
);

   localparam logic [3:0]   CntLoad  = 4'(SETTLE - 1);
   localparam logic [N-1:0] StimLast = {N{1'b1}};

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   state_e     state;
   logic [3:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         cnt       <= '0;
         stim      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         table_a   <= '0;
`ifdef TRUTH_SWEEP_CMP_EN
         table_b   <= '0;
         mismatch  <= 1'b0;
         err_count <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  state     <= StSettle;
                  stim      <= '0;
                  cnt       <= CntLoad;
                  busy      <= 1'b1;
                  table_a   <= '0;
`ifdef TRUTH_SWEEP_CMP_EN
                  table_b   <= '0;
                  mismatch  <= 1'b0;
                  err_count <= '0;
`endif
               end
            end
            StSettle: begin
               if (cnt == 4'd0) state <= StSample;
               else             cnt   <= cnt - 4'd1;
            end
            StSample: begin
               table_a[stim] <= resp_a;
`ifdef TRUTH_SWEEP_CMP_EN
               table_b[stim] <= resp_b;
               if (resp_a != resp_b) begin
                  mismatch  <= 1'b1;
                  err_count <= err_count + (N+1)'(1);
               end
`endif
               if (stim == StimLast) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  stim  <= stim + N'(1);
                  cnt   <= CntLoad;
                  state <= StSettle;
               end
            end
            StDone:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

`ifndef TRUTH_SWEEP_CMP_EN
   // Compare path removed: outputs tied off, resp_b deliberately unused.
   logic unused_resp_b;
   assign unused_resp_b = resp_b;
   assign table_b       = '0;
   assign mismatch      = 1'b0;
   assign err_count     = '0;
`endif

endmodule

// File: tb/tb_truth_sweep.sv
// Directed bench for truth_sweep: SETTLE=1 main instance plus a SETTLE=3 instance.
`timescale 1ns/1ps
module tb_truth_sweep;

`ifdef TRUTH_SWEEP_CMP_EN
   localparam bit CmpEn = 1'b1;
`else
   localparam bit CmpEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, start, start3, bmode, glitch;
   logic [2:0] stim, stim3;
   logic       resp_a, resp_b, resp_a3, resp_b3;
   logic       busy, done, mismatch, busy3, done3, mismatch3;
   logic [7:0] table_a, table_b, table_a3, table_b3;
   logic [3:0] err_count, err_count3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Reference function: minterms {1,2,3,6}, and its simplified form a'c + bc'.
   function automatic logic f_sop(input logic [2:0] s);
      return (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd6);
   endfunction
   function automatic logic f_min(input logic [2:0] s);
      return (~s[2] & s[0]) | (s[1] & ~s[0]);
   endfunction

   assign resp_a  = f_sop(stim);
   assign resp_b  = f_min(stim) ^ (bmode && (stim == 3'd5));
   assign resp_a3 = f_sop(stim3) ^ glitch;
   assign resp_b3 = f_min(stim3);

   truth_sweep #(.N(3), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp_a(resp_a), .resp_b(resp_b),
      .busy(busy), .done(done), .table_a(table_a), .table_b(table_b), .mismatch(mismatch),
      .err_count(err_count)
   );

   truth_sweep #(.N(3), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .stim(stim3), .resp_a(resp_a3),
      .resp_b(resp_b3), .busy(busy3), .done(done3), .table_a(table_a3), .table_b(table_b3),
      .mismatch(mismatch3), .err_count(err_count3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_stim"},  32'(stim), 0);
      check({pfx, "_busy"},  32'(busy), 0);
      check({pfx, "_done"},  32'(done), 0);
      check({pfx, "_ta"},    32'(table_a), 0);
      check({pfx, "_tb"},    32'(table_b), 0);
      check({pfx, "_mis"},   32'(mismatch), 0);
      check({pfx, "_err"},   32'(err_count), 0);
   endtask

   task automatic wait_done();
      int c = 0;
      while (!done && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("done_timeout", 32'(done), 1);
   endtask

   task automatic run_sweep();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, ndone;
      int t [2];
      rst_n = 1'b0; start = 1'b0; start3 = 1'b0; bmode = 1'b0; glitch = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("rst");
      rst_n = 1'b1;

      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (stim != 3'd0 || busy || done) bad++;
      end
      check("idle_quiet", 32'(bad), 0);

      // Cycle-accurate sweep: k counts edges after the accepting edge E.
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 18; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("stim_k%0d", k), 32'(stim), (k / 2 > 7) ? 32'd7 : 32'(k / 2));
         check($sformatf("busy_k%0d", k), 32'(busy), (k < 16) ? 32'd1 : 32'd0);
         check($sformatf("done_k%0d", k), 32'(done), (k == 16) ? 32'd1 : 32'd0);
      end
      check("ta_equiv",  32'(table_a), 32'h4E);
      check("tb_equiv",  32'(table_b), CmpEn ? 32'h4E : 32'h0);
      check("mis_equiv", 32'(mismatch), 0);
      check("err_equiv", 32'(err_count), 0);
      repeat (5) @(negedge clk);
      check("ta_hold", 32'(table_a), 32'h4E);

      // resp_b wrong at vector 5 only.
      bmode = 1'b1;
      run_sweep();
      check("ta_bad5",  32'(table_a), 32'h4E);
      check("tb_bad5",  32'(table_b), CmpEn ? 32'h6E : 32'h0);
      check("mis_bad5", 32'(mismatch), CmpEn ? 32'd1 : 32'd0);
      check("err_bad5", 32'(err_count), CmpEn ? 32'd1 : 32'd0);
      @(negedge clk);
      check("mis_sticky", 32'(mismatch), CmpEn ? 32'd1 : 32'd0);

      // Next accepted start clears the flags.
      bmode = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("mis_clear", 32'(mismatch), 0);
      check("err_clear", 32'(err_count), 0);
      check("tb_clear",  32'(table_b), 0);
      wait_done();

      // Start pulses inside a sweep are ignored.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      ndone = 0;
      for (int k = 2; k < 42; k++) begin
         start = (k == 3 || k == 7 || k == 14);
         @(negedge clk);
         if (done) ndone++;
      end
      start = 1'b0;
      check("one_done", 32'(ndone), 1);

      // Continuous start: done pulses 18 cycles apart.
      t[0] = 0; t[1] = 0; ndone = 0;
      start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (done && ndone < 2) begin
            t[ndone] = c;
            ndone++;
         end
      end
      start = 1'b0;
      check("b2b_gap", 32'(t[1] - t[0]), 18);
      repeat (40) @(negedge clk);

      // Reset mid-sweep at stim == 4.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 40 && stim != 3'd4; c++) @(negedge clk);
      check("reach_s4", 32'(stim), 4);
      #2 rst_n = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("restart_stim", 32'(stim), 0);
      check("restart_busy", 32'(busy), 1);
      wait_done();
      check("ta_restart", 32'(table_a), 32'h4E);

      // SETTLE=3: 4 cycles per vector, glitch in first settle cycle of each.
      @(negedge clk) start3 = 1'b1;
      @(posedge clk);
      @(negedge clk) start3 = 1'b0;
      for (int k = 0; k < 34; k++) begin
         if (k > 0) @(negedge clk);
         glitch = (k % 4 == 0) && (k < 32);
         check($sformatf("s3_stim_k%0d", k), 32'(stim3), (k / 4 > 7) ? 32'd7 : 32'(k / 4));
         check($sformatf("s3_done_k%0d", k), 32'(done3), (k == 32) ? 32'd1 : 32'd0);
      end
      glitch = 1'b0;
      check("s3_ta",  32'(table_a3), 32'h4E);
      check("s3_tb",  32'(table_b3), CmpEn ? 32'h4E : 32'h0);
      check("s3_mis", 32'(mismatch3), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
